// File: rtl/gate_sweep_pkg.sv
// Shared types and constants for the gate truth-table sweeper.
// Imported by the controller and its settle timer.
package gate_sweep_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StDrive,
        StWait,
        StSample,
        StFin
    } sweep_state_e;

    localparam int unsigned VEC_COUNT = 8;
    localparam int unsigned IDX_W     = $clog2(VEC_COUNT);
    localparam int unsigned CNT_W     = 4;

    localparam logic [VEC_COUNT-1:0] NOR3_TABLE = 8'h01;
    localparam logic [IDX_W-1:0]     LAST_IDX   = IDX_W'(VEC_COUNT - 1);
    localparam logic [IDX_W-1:0]     IDX_ONE    = IDX_W'(1);
    localparam logic [CNT_W-1:0]     CNT_ONE    = CNT_W'(1);

endpackage

// File: rtl/gate_sweep_timer.sv
// Settle countdown: load a start value, decrement to zero, flag zero.
// Saturates at zero so a stray decrement never wraps.
module gate_sweep_timer
    import gate_sweep_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Sweeps all eight input vectors of a 3-input gate, captures its truth table
// and compares it with the expected table.
module gate_sweep_ctrl
    import gate_sweep_pkg::*;
#(
    parameter int unsigned          SETTLE = 2,
    parameter logic [VEC_COUNT-1:0] EXP    = NOR3_TABLE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    output logic                 gate_a,
    output logic                 gate_b,
    output logic                 gate_c,
    input  logic                 gate_y,
    output logic                 busy,
    output logic                 done,
    output logic [VEC_COUNT-1:0] truth_table,
    output logic                 pass
);

    // Counter is loaded in DRIVE with SETTLE-1 so WAIT dwells exactly SETTLE cycles.
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE - 1);

    sweep_state_e state_q;
    sweep_state_e state_d;

    logic [IDX_W-1:0]     idx_q;
    logic [VEC_COUNT-1:0] table_q;
    logic                 pass_q;

    logic timer_load;
    logic timer_dec;
    logic timer_zero;
    logic sample_en;
    logic accept;
    logic abort_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    state_d = StDrive;
                end
            end
            StDrive: begin
                state_d = abort ? StIdle : StWait;
            end
            StWait: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (timer_zero) begin
                    state_d = StSample;
                end
            end
            StSample: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (idx_q == LAST_IDX) begin
                    state_d = StFin;
                end else begin
                    state_d = StDrive;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        timer_load = 1'b0;
        timer_dec  = 1'b0;
        sample_en  = 1'b0;
        unique case (state_q)
            StIdle: begin
            end
            StDrive: begin
                busy       = 1'b1;
                timer_load = 1'b1;
            end
            StWait: begin
                busy      = 1'b1;
                timer_dec = 1'b1;
            end
            StSample: begin
                busy      = 1'b1;
                sample_en = 1'b1;
            end
            StFin: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign accept    = (state_q == StIdle) && start && !abort;
    assign abort_hit = busy && abort;

    // idx_q doubles as the registered gate vector: it only moves on entry to
    // DRIVE, and drops to zero on entry to FIN or IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            table_q <= '0;
            pass_q  <= 1'b0;
        end else if (accept || abort_hit) begin
            idx_q   <= '0;
            table_q <= '0;
            pass_q  <= 1'b0;
        end else if (sample_en) begin
            table_q[idx_q] <= gate_y;
            if (idx_q == LAST_IDX) begin
                idx_q <= '0;
            end else begin
                idx_q <= idx_q + IDX_ONE;
            end
        end else if (done) begin
            pass_q <= (table_q == EXP);
        end
    end

    gate_sweep_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (abort_hit),
        .load     (timer_load),
        .dec      (timer_dec),
        .load_val (SETTLE_LD),
        .zero     (timer_zero)
    );

    assign {gate_a, gate_b, gate_c} = idx_q;
    assign truth_table              = table_q;
    assign pass                     = pass_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Randomized bench for gate_sweep_ctrl: two instances (SETTLE=2 and SETTLE=1)
// driving a table-defined gate, checked cycle by cycle against a timing model.
module tb_gate_sweep_ctrl;

    logic       clk;
    logic       rst_n;
    logic [1:0] start_s;
    logic [1:0] abort_s;
    logic [7:0] gtab;

    logic       ga0, gb0, gc0, gy0, busy0, done0, pass0;
    logic       ga1, gb1, gc1, gy1, busy1, done1, pass1;
    logic [7:0] tab0, tab1;

    int         sel;
    logic [2:0] obs_gates;
    logic       obs_busy, obs_done, obs_pass;
    logic [7:0] obs_table;

    int         n_vec;
    int         n_err;
    logic [7:0] nor_tab;
    logic [7:0] last_table [2];
    logic       last_pass  [2];

    // Gate under test is an arbitrary truth table looked up by its inputs.
    assign gy0 = gtab[{ga0, gb0, gc0}];
    assign gy1 = gtab[{ga1, gb1, gc1}];

    gate_sweep_ctrl #(.SETTLE(2)) dut0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start_s[0]),
        .abort       (abort_s[0]),
        .gate_a      (ga0),
        .gate_b      (gb0),
        .gate_c      (gc0),
        .gate_y      (gy0),
        .busy        (busy0),
        .done        (done0),
        .truth_table (tab0),
        .pass        (pass0)
    );

    gate_sweep_ctrl #(.SETTLE(1)) dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start_s[1]),
        .abort       (abort_s[1]),
        .gate_a      (ga1),
        .gate_b      (gb1),
        .gate_c      (gc1),
        .gate_y      (gy1),
        .busy        (busy1),
        .done        (done1),
        .truth_table (tab1),
        .pass        (pass1)
    );

    always_comb begin
        if (sel == 0) begin
            obs_gates = {ga0, gb0, gc0};
            obs_busy  = busy0;
            obs_done  = done0;
            obs_table = tab0;
            obs_pass  = pass0;
        end else begin
            obs_gates = {ga1, gb1, gc1};
            obs_busy  = busy1;
            obs_done  = done1;
            obs_table = tab1;
            obs_pass  = pass1;
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle_clear(input string tag);
        check_eq({tag, "_busy"}, 32'(obs_busy), 32'd0);
        check_eq({tag, "_done"}, 32'(obs_done), 32'd0);
        check_eq({tag, "_gates"}, 32'(obs_gates), 32'd0);
        check_eq({tag, "_table"}, 32'(obs_table), 32'd0);
        check_eq({tag, "_pass"}, 32'(obs_pass), 32'd0);
    endtask

    // One sweep on instance inst with gate table gt. abort_m / rst_m give the
    // cycle offset after the accepting edge at which to abort or reset (-1: none).
    task automatic do_sweep(input int inst, input logic [7:0] gt, input int abort_m,
                            input int rst_m, input bit hold);
        int         s;
        int         per;
        int         total;
        int         nf;
        logic [8:0] msk;
        s     = (inst == 0) ? 2 : 1;
        per   = s + 2;
        total = 8 * per;
        sel   = inst;
        gtab  = gt;
        @(negedge clk);
        check_eq("hold_table", 32'(obs_table), 32'(last_table[inst]));
        check_eq("hold_pass", 32'(obs_pass), 32'(last_pass[inst]));
        start_s[inst] = 1'b1;
        for (int m = 0; m <= total; m++) begin
            @(negedge clk);
            if (!hold) start_s[inst] = 1'b0;
            nf  = m / per;
            msk = (9'd1 << nf) - 9'd1;
            if (m < total) begin
                check_eq("run_busy", 32'(obs_busy), 32'd1);
                check_eq("run_done", 32'(obs_done), 32'd0);
                check_eq("run_gates", 32'(obs_gates), 32'(m / per));
            end else begin
                check_eq("fin_busy", 32'(obs_busy), 32'd0);
                check_eq("fin_done", 32'(obs_done), 32'd1);
                check_eq("fin_gates", 32'(obs_gates), 32'd0);
            end
            check_eq("run_table", 32'(obs_table), 32'(gt & msk[7:0]));
            if (m == abort_m) begin
                abort_s[inst] = 1'b1;
                @(negedge clk);
                abort_s[inst] = 1'b0;
                check_idle_clear("abort");
                last_table[inst] = 8'h00;
                last_pass[inst]  = 1'b0;
                repeat (2 * per) begin
                    @(negedge clk);
                    check_eq("abort_nodone", 32'(obs_done), 32'd0);
                    check_eq("abort_idle", 32'(obs_busy), 32'd0);
                end
                return;
            end
            if (m == rst_m) begin
                rst_n = 1'b0;
                #1;
                check_idle_clear("rst_async");
                @(negedge clk);
                check_idle_clear("rst_hold");
                rst_n = 1'b1;
                for (int k = 0; k < 2; k++) begin
                    last_table[k] = 8'h00;
                    last_pass[k]  = 1'b0;
                end
                repeat (3) begin
                    @(negedge clk);
                    check_eq("rst_nostart", 32'(obs_busy), 32'd0);
                end
                return;
            end
        end
        @(negedge clk);
        check_eq("end_busy", 32'(obs_busy), 32'd0);
        check_eq("end_done", 32'(obs_done), 32'd0);
        check_eq("end_gates", 32'(obs_gates), 32'd0);
        check_eq("end_table", 32'(obs_table), 32'(gt));
        check_eq("end_pass", 32'(obs_pass), 32'(gt == nor_tab));
        last_table[inst] = gt;
        last_pass[inst]  = (gt == nor_tab);
        if (hold) begin
            @(negedge clk);
            check_eq("retrig_busy", 32'(obs_busy), 32'd1);
            check_eq("retrig_gates", 32'(obs_gates), 32'd0);
            start_s[inst] = 1'b0;
            abort_s[inst] = 1'b1;
            @(negedge clk);
            abort_s[inst] = 1'b0;
            check_idle_clear("retrig_abort");
            last_table[inst] = 8'h00;
            last_pass[inst]  = 1'b0;
        end
    endtask

    initial begin
        int         inst;
        logic [7:0] gt;
        n_vec   = 0;
        n_err   = 0;
        sel     = 0;
        start_s = 2'b00;
        abort_s = 2'b00;
        for (int i = 0; i < 8; i++) begin
            nor_tab[i] = ~(|i[2:0]);
        end
        gtab  = nor_tab;
        for (int k = 0; k < 2; k++) begin
            last_table[k] = 8'h00;
            last_pass[k]  = 1'b0;
        end

        // Asynchronous reset before any clock edge.
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst0_out", 32'({ga0, gb0, gc0, busy0, done0, pass0, tab0}), 32'd0);
        check_eq("rst1_out", 32'({ga1, gb1, gc1, busy1, done1, pass1, tab1}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_eq("post_rst_idle0", 32'(busy0), 32'd0);
            check_eq("post_rst_idle1", 32'(busy1), 32'd0);
        end

        // start and abort together in IDLE: abort wins.
        start_s = 2'b11;
        abort_s = 2'b11;
        repeat (3) begin
            @(negedge clk);
            check_eq("sa_idle0", 32'(busy0), 32'd0);
            check_eq("sa_idle1", 32'(busy1), 32'd0);
        end
        start_s = 2'b00;
        abort_s = 2'b00;

        do_sweep(0, nor_tab, -1, -1, 1'b0);
        do_sweep(0, 8'h00, -1, -1, 1'b0);
        do_sweep(1, 8'h00, -1, -1, 1'b0);
        do_sweep(1, nor_tab, -1, -1, 1'b0);
        do_sweep(0, nor_tab, -1, -1, 1'b1);
        do_sweep(0, 8'($urandom) | 8'h10, 4 * 4 + 1, -1, 1'b0);
        do_sweep(1, 8'($urandom), 4 * 3 + 1, -1, 1'b0);
        do_sweep(0, nor_tab, -1, 7 * 4 - 1, 1'b0);
        do_sweep(0, nor_tab, -1, -1, 1'b0);

        for (int r = 0; r < 8; r++) begin
            inst = int'($urandom_range(0, 1));
            gt   = ($urandom_range(0, 3) == 0) ? nor_tab : 8'($urandom);
            do_sweep(inst, gt, -1, -1, 1'b0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gate_sweep_ctrl.md
GATE_SWEEP_CTRL -- requirements
Module: gate_sweep_ctrl

Interface
REQ-001 Parameter SETTLE, default 2, meaning: wait cycles between driving a vector and sampling gate_y; legal range 1..15.
REQ-002 Parameter EXP, default 8'h01, meaning: expected truth table; bit i = expected y for {a,b,c} = i, a is MSB (3-input NOR).
REQ-003 clk  input  1  sole clock, rising-edge active.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request a full sweep; sampled only in IDLE.
REQ-006 abort  input  1  cancel a sweep in progress.
REQ-007 gate_a, gate_b, gate_c  output  1 each  registered vector driven to the gate under test.
REQ-008 gate_y  input  1  gate-under-test output.
REQ-009 busy  output  1  high in DRIVE, WAIT and SAMPLE.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 table  output  8  captured truth table, bit i = sampled y for vector i.
REQ-012 pass  output  1  table == EXP for the last completed sweep.

Function
REQ-013 The FSM SHALL have states IDLE, DRIVE, WAIT, SAMPLE and FIN.
REQ-014 IDLE: start=1 and abort=0 -> DRIVE; vector index idx=0; table and pass cleared.
REQ-015 DRIVE: {gate_a,gate_b,gate_c}=idx; settle counter loaded with SETTLE-1; -> WAIT.
REQ-016 WAIT: counter==0 -> SAMPLE, else decrement; dwell is exactly SETTLE cycles.
REQ-017 SAMPLE: table[idx] <= gate_y; idx==7 -> FIN; otherwise idx+1 -> DRIVE (no wrap past 7).
REQ-018 FIN: done=1 for exactly one cycle; pass <= (table==EXP); idx and gate inputs return to 3'b000; -> IDLE.
REQ-019 Each vector SHALL take SETTLE+2 cycles; done SHALL be high in the cycle after 8*(SETTLE+2) rising edges from the edge that accepts start (32 for SETTLE=2).
REQ-020 Gate inputs SHALL be 3'b000 in IDLE and FIN and SHALL change only on entry to DRIVE.
REQ-021 start SHALL be ignored in any state other than IDLE; a held start re-triggers only after returning to IDLE.
REQ-022 abort=1 while busy SHALL force IDLE on the next edge, with no done; table cleared, pass=0, gate inputs 000.
REQ-023 When start and abort are high together in IDLE, abort SHALL win and the FSM SHALL stay in IDLE.
REQ-024 table and pass SHALL hold their values from the last completed sweep until the next start is accepted.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE, idx=0, counter=0, gate inputs 000, busy=0, done=0, table=8'h00 and pass=0, including mid-sweep.
REQ-026 The first sweep after rst_n deassertion SHALL require a fresh start in IDLE.

Structure
REQ-027 Package gate_sweep_pkg SHALL hold the state enum, VEC_COUNT=8 and the constant NOR3_TABLE=8'h01.
REQ-028 The settle countdown SHALL be the sub-module gate_sweep_timer (load, decrement, zero flag); all other logic SHALL be in gate_sweep_ctrl.

Verification
REQ-029 Reset: rst_n low -> every output 0 and gate inputs 000, with no clock edge required.
REQ-030 Ideal NOR model on gate_y, SETTLE=2, start pulse -> vectors 000..111 each held 4 cycles; done after 32 edges; table=8'h01; pass=1.
REQ-031 gate_y tied 0 -> table=8'h00, pass=0. Same run with SETTLE=1 -> done after 24 edges.
REQ-032 start held high for 40 cycles -> exactly one done within the first 32+1 edges; a second sweep begins only after IDLE is re-entered.
REQ-033 abort pulsed during the vector-4 WAIT -> busy low next cycle; no done; table=8'h00; gate inputs 000.
REQ-034 rst_n pulsed low during the vector-6 SAMPLE -> outputs clear asynchronously; a following start completes a normal sweep with pass=1.
